// File: rtl/program_counter_if.sv
// Signal bundle between upstream next-PC logic and the program counter register.
interface program_counter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              enable;
  logic [ADDR_W-1:0] addr_in;
  logic [ADDR_W-1:0] addr_out;
  logic [ADDR_W-1:0] addr_plus4;
  logic              misaligned;
  logic              loaded;

  modport master (
    output enable, addr_in,
    input  addr_out, addr_plus4, misaligned, loaded
  );

  modport slave (
    input  enable, addr_in,
    output addr_out, addr_plus4, misaligned, loaded
  );
endinterface

// File: rtl/program_counter.sv
// Program counter register: loads addr_in on enabled edges, exposes PC+4,
// a misalignment flag, and a sticky "loaded since reset" indicator.
module program_counter #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst_n,
  program_counter_if.slave pc
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              loaded_q, loaded_d;

  always_comb begin
    addr_d   = addr_q;
    loaded_d = loaded_q;
    if (pc.enable) begin
      addr_d   = pc.addr_in;
      loaded_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= RESET_ADDR;
      loaded_q <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      loaded_q <= loaded_d;
    end
  end

  // Derived outputs come only from the register, never from addr_in.
  assign pc.addr_out   = addr_q;
  assign pc.addr_plus4 = addr_q + ADDR_W'(4);
  assign pc.misaligned = |addr_q[1:0];
  assign pc.loaded     = loaded_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed plus randomized checks of program_counter against a simple PC model.
module tb_program_counter;

  logic clk;
  logic rst_n;

  program_counter_if #(.ADDR_W(32)) pc_if ();

  program_counter #(
    .ADDR_W    (32),
    .RESET_ADDR(32'h0000_0000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .pc   (pc_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total;
  int unsigned fails;

  // Reference model: the PC value and whether any load happened since reset.
  logic [31:0] exp_addr;
  logic        exp_loaded;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [32:0] sum;
    sum = {1'b0, exp_addr} + 33'd4;
    chk({tag, ".addr_out"},   pc_if.addr_out,            exp_addr);
    chk({tag, ".addr_plus4"}, pc_if.addr_plus4,          sum[31:0]);
    chk({tag, ".misaligned"}, {31'd0, pc_if.misaligned}, {31'd0, (exp_addr % 4) != 0});
    chk({tag, ".loaded"},     {31'd0, pc_if.loaded},     {31'd0, exp_loaded});
  endtask

  task automatic step(input string tag, input logic en, input logic [31:0] addr);
    @(negedge clk);
    pc_if.enable  = en;
    pc_if.addr_in = addr;
    @(posedge clk);
    if (en) begin
      exp_addr   = addr;
      exp_loaded = 1'b1;
    end
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag, input logic [31:0] junk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_addr   = 32'h0;
    exp_loaded = 1'b0;
    #1;
    check_all({tag, ".immediate"});
    pc_if.enable  = 1'b1;
    pc_if.addr_in = junk;
    @(posedge clk);
    #1;
    check_all({tag, ".edge_in_reset"});
    @(negedge clk);
    rst_n = 1'b1;
    pc_if.enable = 1'b0;
  endtask

  initial begin
    total = 0;
    fails = 0;
    rst_n         = 1'b0;
    pc_if.enable  = 1'b0;
    pc_if.addr_in = 32'h0;
    exp_addr      = 32'h0;
    exp_loaded    = 1'b0;

    #100;
    rst_n = 1'b1;
    #1;
    check_all("powerup");

    for (int i = 0; i < 3; i++) step("hold", 1'b0, 32'h0000_0040);

    step("load1", 1'b1, 32'h0000_0004);
    step("load2", 1'b1, 32'h0000_0008);
    step("load3", 1'b1, 32'h0000_0100);

    async_reset("arst", 32'h0000_0200);
    step("after_arst_hold", 1'b0, 32'h0000_0300);
    step("after_arst_load", 1'b1, 32'h0000_0100);

    step("wrap_fffc", 1'b1, 32'hFFFF_FFFC);
    step("wrap_fffe", 1'b1, 32'hFFFF_FFFE);
    step("mis_0002",  1'b1, 32'h0000_0002);

    for (int i = 0; i < 8; i++)
      step("toggle", (i % 2) == 0, 32'h0000_1000 + 32'(i) * 4);

    for (int i = 0; i < 300; i++) begin
      int unsigned r;
      logic [31:0] a;
      r = $urandom_range(0, 19);
      if ((r % 3) == 0) a = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      else              a = $urandom;
      if (r == 0) async_reset("rand_arst", a);
      else        step("rand", ($urandom_range(0, 1) == 1), a);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
